// File: rtl/muldiv_pkg.sv
// Shared types and RV32M encodings for the EX-stage multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic [2:0] F3_MUL  = 3'b000;
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [6:0] FUNCT7_M = 7'b0000001;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side bundle of the multiply/divide unit.
// The pipeline drives the master side; the unit is the slave.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);

  logic            valid_i;
  logic [9:0]      funct_i;
  logic [XLEN-1:0] reg1Data_i;
  logic [XLEN-1:0] reg2Data_i;
  logic            kill_i;
  logic            is_m_o;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, funct_i, reg1Data_i, reg2Data_i, kill_i,
    input  is_m_o, stall_o, done_o, result_o
  );

  modport slave (
    input  valid_i, funct_i, reg1Data_i, reg2Data_i, kill_i,
    output is_m_o, stall_o, done_o, result_o
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add (mode=0) or restoring-divide
// step (mode=1).
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] operand,
  input  logic            mode,
  input  logic            bit_in,
  output logic [XLEN-1:0] acc_nxt,
  output logic            q_bit
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] sub_lo;
  logic            ge;

  // The partial remainder stays below the divisor, so the low
  // XLEN bits of the difference are exact whenever ge is set.
  assign shifted = {acc, bit_in};
  assign ge      = shifted >= {1'b0, operand};
  assign sub_lo  = shifted[XLEN-1:0] - operand;

  always_comb begin
    q_bit   = 1'b0;
    acc_nxt = acc + (bit_in ? operand : '0);
    if (mode) begin
      q_bit   = ge;
      acc_nxt = ge ? sub_lo : shifted[XLEN-1:0];
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M MUL/DIV/DIVU/REM/REMU unit for the EX stage.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  ex_muldiv_unit_if.slave bus
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] acc, opa, opb, result;
  logic            is_div, is_rem, neg_q, neg_r;

  logic [2:0]      f3_in;
  logic [XLEN-1:0] a, b, abs_a, abs_b, spec_res;
  logic            accept, sgn_in, s1, s2, go_calc;
  logic            bit_in, q_bit;
  logic [XLEN-1:0] acc_nxt, q_fin, fin;

  assign a     = bus.reg1Data_i;
  assign b     = bus.reg2Data_i;
  assign f3_in = bus.funct_i[2:0];

  assign bus.is_m_o   = bus.valid_i
                     && (bus.funct_i[9:3] == FUNCT7_M);
  assign accept       = (state == IDLE) && bus.is_m_o
                     && !bus.kill_i;
  assign bus.stall_o  = accept || (state == CALC);
  assign bus.done_o   = (state == DONE);
  assign bus.result_o = result;

  assign sgn_in = (f3_in == F3_DIV) || (f3_in == F3_REM);
  assign s1     = sgn_in && a[XLEN-1];
  assign s2     = sgn_in && b[XLEN-1];
  assign abs_a  = s1 ? -a : a;
  assign abs_b  = s2 ? -b : b;

  // Divide-by-zero, signed overflow and MULH* finish in one cycle.
  always_comb begin
    go_calc  = 1'b0;
    spec_res = '0;
    if (f3_in == F3_MUL) begin
      go_calc = 1'b1;
    end else if (f3_in[2]) begin
      if (b == '0)
        spec_res = f3_in[1] ? a : '1;
      else if (sgn_in && a == MIN_NEG && b == '1)
        spec_res = f3_in[1] ? '0 : MIN_NEG;
      else
        go_calc = 1'b1;
    end
  end

  assign bit_in = is_div ? opa[XLEN-1] : opa[0];

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc     (acc),
    .operand (opb),
    .mode    (is_div),
    .bit_in  (bit_in),
    .acc_nxt (acc_nxt),
    .q_bit   (q_bit)
  );

  assign q_fin = {opa[XLEN-2:0], q_bit};

  always_comb begin
    fin = acc_nxt;
    if (is_div)
      fin = is_rem ? (neg_r ? -acc_nxt : acc_nxt)
                   : (neg_q ? -q_fin : q_fin);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          is_div <= f3_in[2];
          is_rem <= f3_in[1];
          neg_q  <= s1 ^ s2;
          neg_r  <= s1;
          acc    <= '0;
          opa    <= f3_in[2] ? abs_a : b;
          opb    <= f3_in[2] ? abs_b : a;
          if (go_calc) begin
            cnt   <= CNT_W'(XLEN);
            state <= CALC;
          end else begin
            result <= spec_res;
            state  <= DONE;
          end
        end
        CALC: if (bus.kill_i) begin
          state <= IDLE;
        end else begin
          acc <= acc_nxt;
          opa <= is_div ? q_fin : (opa >> 1);
          if (!is_div) opb <= opb << 1;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            result <= fin;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
